// File: rtl/reg_status_ctrl_pkg.sv
// reg_status_ctrl_pkg: shared sizes, FSM encoding and boolean constants for the register status tracker
package reg_status_ctrl_pkg;
  localparam int DEF_REG_NUM = 32;
  localparam int DEF_ROB_ID_W = 4;
  localparam int DEF_DATA_W = 32;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;
endpackage

// File: rtl/reg_tag_table.sv
// reg_tag_table: busy/tag scoreboard with issue > commit-clear > hold priority and flush override
module reg_tag_table
  import reg_status_ctrl_pkg::*;
#(
  parameter int REG_NUM = DEF_REG_NUM,
  parameter int ROB_ID_W = DEF_ROB_ID_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  input  logic                iss_we,
  input  logic [4:0]          iss_rd,
  input  logic [ROB_ID_W-1:0] iss_rob_id,
  input  logic                cmt_valid,
  input  logic [4:0]          cmt_rd,
  input  logic [ROB_ID_W-1:0] cmt_rob_id,
  output logic [REG_NUM-1:0]  busy,
  output logic [ROB_ID_W-1:0] tag [REG_NUM],
  output logic [5:0]          busy_cnt
);
  logic iss_hit, cmt_hit, inc;
  assign iss_hit = iss_we && iss_rd != 5'd0;
  // an issue to the same register supersedes its commit-clear
  assign cmt_hit = cmt_valid && rdy && cmt_rd != 5'd0 && busy[cmt_rd] && tag[cmt_rd] == cmt_rob_id
                   && !(iss_hit && iss_rd == cmt_rd);
  assign inc = iss_hit && !busy[iss_rd];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
      busy_cnt <= '0;
      for (int i = 0; i < REG_NUM; i++) tag[i] <= '0;
    end else if (rdy) begin
      if (flush) begin
        busy <= '0;
        busy_cnt <= '0;
      end else begin
        if (iss_hit) begin
          busy[iss_rd] <= TRUE;
          tag[iss_rd] <= iss_rob_id;
        end
        if (cmt_hit) busy[cmt_rd] <= FALSE;
        busy_cnt <= busy_cnt + 6'(inc) - 6'(cmt_hit);
      end
    end
  end
endmodule

// File: rtl/reg_status_ctrl.sv
// reg_status_ctrl: register status tracking with issue/commit handshakes, commit forwarding and a registered write port
module reg_status_ctrl
  import reg_status_ctrl_pkg::*;
#(
  parameter int REG_NUM = DEF_REG_NUM,
  parameter int ROB_ID_W = DEF_ROB_ID_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                iss_valid,
  output logic                iss_ready,
  input  logic [4:0]          iss_rd,
  input  logic [ROB_ID_W-1:0] iss_rob_id,
  input  logic                cmt_valid,
  input  logic [4:0]          cmt_rd,
  input  logic [ROB_ID_W-1:0] cmt_rob_id,
  input  logic [DATA_W-1:0]   cmt_data,
  input  logic                flush,
  input  logic [4:0]          rs1_idx,
  output logic                rs1_busy,
  output logic [ROB_ID_W-1:0] rs1_tag,
  output logic                rs1_fwd,
  output logic [DATA_W-1:0]   rs1_fwd_data,
  input  logic [4:0]          rs2_idx,
  output logic                rs2_busy,
  output logic [ROB_ID_W-1:0] rs2_tag,
  output logic                rs2_fwd,
  output logic [DATA_W-1:0]   rs2_fwd_data,
  output logic                wr_en,
  output logic [4:0]          wr_idx,
  output logic [DATA_W-1:0]   wr_data,
  output logic [5:0]          busy_cnt
);
  state_e state, state_nx;
  logic [REG_NUM-1:0] busy;
  logic [ROB_ID_W-1:0] tag [REG_NUM];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else state <= state_nx;
  end
  always_comb state_nx = rdy ? (flush ? FLUSH : RUN) : state;
  always_comb iss_ready = rst && rdy && state == RUN && !flush;
  reg_tag_table #(.REG_NUM(REG_NUM), .ROB_ID_W(ROB_ID_W)) u_table (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .iss_we(iss_valid && iss_ready), .iss_rd(iss_rd), .iss_rob_id(iss_rob_id),
    .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_rob_id(cmt_rob_id),
    .busy(busy), .tag(tag), .busy_cnt(busy_cnt)
  );
  // a matching commit this cycle resolves the source without waiting for the write
  always_comb begin
    rs1_fwd = cmt_valid && cmt_rd == rs1_idx && busy[rs1_idx] && tag[rs1_idx] == cmt_rob_id;
    rs2_fwd = cmt_valid && cmt_rd == rs2_idx && busy[rs2_idx] && tag[rs2_idx] == cmt_rob_id;
    rs1_busy = busy[rs1_idx] && !rs1_fwd;
    rs2_busy = busy[rs2_idx] && !rs2_fwd;
    rs1_tag = tag[rs1_idx];
    rs2_tag = tag[rs2_idx];
    rs1_fwd_data = rs1_fwd ? cmt_data : '0;
    rs2_fwd_data = rs2_fwd ? cmt_data : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en <= 1'b0;
      wr_idx <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= rdy && cmt_valid && cmt_rd != 5'd0;
      if (rdy && cmt_valid) begin
        wr_idx <= cmt_rd;
        wr_data <= cmt_data;
      end
    end
  end
endmodule

// File: tb/tb_reg_status_ctrl.sv
// tb_reg_status_ctrl: directed scenarios plus randomized traffic checked every cycle against a behavioural model
module tb_reg_status_ctrl;
  logic clk = 1'b0, rst = 1'b0, rdy = 1'b0;
  logic iss_valid = 1'b0, cmt_valid = 1'b0, flush = 1'b0;
  logic [4:0] iss_rd = '0, cmt_rd = '0, rs1_idx = '0, rs2_idx = '0;
  logic [3:0] iss_rob_id = '0, cmt_rob_id = '0;
  logic [31:0] cmt_data = '0;
  logic iss_ready, rs1_busy, rs1_fwd, rs2_busy, rs2_fwd, wr_en;
  logic [3:0] rs1_tag, rs2_tag;
  logic [31:0] rs1_fwd_data, rs2_fwd_data, wr_data;
  logic [4:0] wr_idx;
  logic [5:0] busy_cnt;
  int npass = 0, ntot = 0;

  reg_status_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd), .iss_rob_id(iss_rob_id),
    .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_rob_id(cmt_rob_id), .cmt_data(cmt_data),
    .flush(flush),
    .rs1_idx(rs1_idx), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_fwd(rs1_fwd), .rs1_fwd_data(rs1_fwd_data),
    .rs2_idx(rs2_idx), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_fwd(rs2_fwd), .rs2_fwd_data(rs2_fwd_data),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  // reference state: plain arrays of what each register is waiting on
  bit m_busy [32];
  bit [3:0] m_tag [32];
  bit m_in_flush, m_wr_en;
  bit [4:0] m_wr_idx;
  bit [31:0] m_wr_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic bit m_match(input logic [4:0] idx);
    return cmt_valid && cmt_rd == idx && m_busy[idx] && m_tag[idx] == cmt_rob_id;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_tag[i] = 0; end
      m_in_flush = 0; m_wr_en = 0; m_wr_idx = 0; m_wr_data = 0;
    end else if (rdy) begin
      bit acc;
      acc = iss_valid && !m_in_flush && !flush;
      if (cmt_valid && m_busy[cmt_rd] && m_tag[cmt_rd] == cmt_rob_id) m_busy[cmt_rd] = 0;
      if (acc && iss_rd != 0) begin m_busy[iss_rd] = 1; m_tag[iss_rd] = iss_rob_id; end
      if (flush) for (int i = 0; i < 32; i++) m_busy[i] = 0;
      m_wr_en = cmt_valid && cmt_rd != 0;
      if (cmt_valid) begin m_wr_idx = cmt_rd; m_wr_data = cmt_data; end
      m_in_flush = flush;
    end else m_wr_en = 0;
  end

  always @(negedge clk) begin
    int pc;
    pc = 0;
    for (int i = 0; i < 32; i++) pc += int'(m_busy[i]);
    chk("iss_ready", iss_ready, rst && rdy && !m_in_flush && !flush);
    chk("rs1_busy", rs1_busy, m_busy[rs1_idx] && !m_match(rs1_idx));
    chk("rs1_tag", rs1_tag, m_tag[rs1_idx]);
    chk("rs1_fwd", rs1_fwd, m_match(rs1_idx));
    chk("rs1_fwd_data", rs1_fwd_data, m_match(rs1_idx) ? cmt_data : 32'd0);
    chk("rs2_busy", rs2_busy, m_busy[rs2_idx] && !m_match(rs2_idx));
    chk("rs2_tag", rs2_tag, m_tag[rs2_idx]);
    chk("rs2_fwd", rs2_fwd, m_match(rs2_idx));
    chk("rs2_fwd_data", rs2_fwd_data, m_match(rs2_idx) ? cmt_data : 32'd0);
    chk("wr_en", wr_en, m_wr_en);
    if (m_wr_en) begin
      chk("wr_idx", wr_idx, m_wr_idx);
      chk("wr_data", wr_data, m_wr_data);
    end
    chk("busy_cnt", busy_cnt, pc);
  end

  task automatic drive(input bit iv, input bit [4:0] ird, input bit [3:0] irob,
                       input bit cv, input bit [4:0] crd, input bit [3:0] crob,
                       input bit [31:0] cd, input bit fl);
    iss_valid = iv; iss_rd = ird; iss_rob_id = irob;
    cmt_valid = cv; cmt_rd = crd; cmt_rob_id = crob; cmt_data = cd; flush = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rdy = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_iss_ready", iss_ready, 0);
    chk("rst_busy_cnt", busy_cnt, 0);
    chk("rst_wr_en", wr_en, 0);
    rst = 1;
    #1 chk("rel_iss_ready", iss_ready, 1);
    drive(1, 5, 3, 0, 0, 0, 0, 0); tick; drive(0, 0, 0, 0, 0, 0, 0, 0);
    rs1_idx = 5;
    #1;
    chk("d1_busy", rs1_busy, 1); chk("d1_tag", rs1_tag, 3); chk("d1_cnt", busy_cnt, 1);
    rs2_idx = 5;
    drive(0, 0, 0, 1, 5, 3, 32'hDEADBEEF, 0);
    #1;
    chk("d2_fwd", rs2_fwd, 1); chk("d2_fwd_data", rs2_fwd_data, 32'hDEADBEEF); chk("d2_busy", rs2_busy, 0);
    tick; drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("d2_wr_en", wr_en, 1); chk("d2_wr_idx", wr_idx, 5); chk("d2_wr_data", wr_data, 32'hDEADBEEF);
    chk("d2_busy5", rs1_busy, 0); chk("d2_cnt", busy_cnt, 0);
    drive(1, 7, 1, 0, 0, 0, 0, 0); tick;
    drive(1, 7, 2, 0, 0, 0, 0, 0); tick;
    drive(0, 0, 0, 1, 7, 1, 32'h1111, 0); tick; drive(0, 0, 0, 0, 0, 0, 0, 0);
    rs1_idx = 7;
    #1;
    chk("d3_wr_en", wr_en, 1); chk("d3_wr_idx", wr_idx, 7);
    chk("d3_busy", rs1_busy, 1); chk("d3_tag", rs1_tag, 2); chk("d3_cnt", busy_cnt, 1);
    drive(1, 9, 6, 0, 0, 0, 0, 0); tick;
    drive(1, 9, 4, 1, 9, 6, 32'h2222, 0); tick; drive(0, 0, 0, 0, 0, 0, 0, 0);
    rs1_idx = 9;
    #1;
    chk("d4_busy", rs1_busy, 1); chk("d4_tag", rs1_tag, 4); chk("d4_cnt", busy_cnt, 2);
    chk("d4_wr_en", wr_en, 1); chk("d4_wr_idx", wr_idx, 9);
    drive(1, 2, 5, 0, 0, 0, 0, 0); tick; drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("d5_cnt3", busy_cnt, 3);
    drive(0, 0, 0, 1, 2, 5, 32'h3333, 1);
    #1 chk("d5_rdy_flush", iss_ready, 0);
    tick; drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("d5_wr_en", wr_en, 1); chk("d5_wr_idx", wr_idx, 2);
    chk("d5_cnt0", busy_cnt, 0); chk("d5_rdy_state", iss_ready, 0);
    tick;
    chk("d5_rdy_back", iss_ready, 1);
    drive(1, 0, 1, 1, 0, 1, 32'h4444, 0); tick; drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("d6_wr_en", wr_en, 0); chk("d6_cnt", busy_cnt, 0);
    drive(1, 3, 7, 1, 4, 0, 32'h5555, 0); tick; drive(0, 0, 0, 0, 0, 0, 0, 0);
    rs1_idx = 3;
    #1;
    chk("d6_wr_en1", wr_en, 1); chk("d6_cnt1", busy_cnt, 1); chk("d6_busy3", rs1_busy, 1);
    rst = 0;
    #1;
    chk("d6r_iss_ready", iss_ready, 0); chk("d6r_cnt", busy_cnt, 0); chk("d6r_wr_en", wr_en, 0);
    chk("d6r_wr_idx", wr_idx, 0); chk("d6r_wr_data", wr_data, 0);
    chk("d6r_busy", rs1_busy, 0); chk("d6r_tag", rs1_tag, 0);
    tick;
    rst = 1;
    for (int n = 0; n < 3000; n++) begin
      bit [4:0] crd;
      crd = 5'($urandom_range(0, 7));
      rdy = ($urandom_range(0, 9) != 0);
      drive($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), 4'($urandom),
            $urandom_range(0, 1) == 1, crd,
            ($urandom_range(0, 2) != 0) ? m_tag[crd] : 4'($urandom),
            $urandom, $urandom_range(0, 19) == 0);
      rs1_idx = 5'($urandom_range(0, 7));
      rs2_idx = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) rst = 0;
      tick;
      rst = 1;
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
